// File: rtl/bcd_updown_counter.sv
// Two-digit BCD up/down counter with parallel load, cascade carry/borrow and sticky load-error flag.
// Optional macro BCD_SATURATE_EN: hold at 99 (up) / 00 (down) instead of wrapping.
module bcd_updown_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       up,
   input  logic       ld,
   input  logic [7:0] din,
   output logic [7:0] q,
   output logic       co,
   output logic       err
);

   logic [7:0] q_r;
   logic [7:0] q_next_s;
   logic       err_r;
   logic       err_next_s;
   logic       at_max_s;
   logic       at_min_s;
   logic       din_ok_s;

   function automatic logic is_bcd_digit(input logic [3:0] d);
      return (d <= 4'd9);
   endfunction

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] >= 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'd0) begin
         r = {v[7:4] - 4'd1, 4'd9};
      end else begin
         r = {v[7:4], v[3:0] - 4'd1};
      end
      return r;
   endfunction

   assign at_max_s = (q_r == 8'h99);
   assign at_min_s = (q_r == 8'h00);
   assign din_ok_s = is_bcd_digit(din[7:4]) & is_bcd_digit(din[3:0]);

   // Next-state selection: load beats count; a rejected load also suppresses counting.
   always_comb begin
      q_next_s   = q_r;
      err_next_s = err_r;
      case ({ld, en})
         2'b10, 2'b11: begin
            if (din_ok_s) begin
               q_next_s   = din;
               err_next_s = 1'b0;
            end else begin
               err_next_s = 1'b1;
            end
         end
         2'b01: begin
            if (up) begin
               if (at_max_s) begin
`ifdef BCD_SATURATE_EN
                  q_next_s = 8'h99;
`else
                  q_next_s = 8'h00;
`endif
               end else begin
                  q_next_s = bcd_inc(q_r);
               end
            end else begin
               if (at_min_s) begin
`ifdef BCD_SATURATE_EN
                  q_next_s = 8'h00;
`else
                  q_next_s = 8'h99;
`endif
               end else begin
                  q_next_s = bcd_dec(q_r);
               end
            end
         end
         default: begin
            q_next_s   = q_r;
            err_next_s = err_r;
         end
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_r   <= 8'h00;
         err_r <= 1'b0;
      end else begin
         q_r   <= q_next_s;
         err_r <= err_next_s;
      end
   end

   assign q   = q_r;
   assign err = err_r;
   // Terminal count is unregistered so a cascaded stage steps on the same edge.
   assign co  = en & ~ld & ((up & at_max_s) | (~up & at_min_s));

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed self-checking bench for bcd_updown_counter, including a two-stage cascade.
module tb_bcd_updown_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic       up = 1'b0;
   logic       ld = 1'b0;
   logic [7:0] din = 8'h00;
   logic [7:0] q;
   logic       co;
   logic       err;

   logic       casc_en = 1'b0;
   logic       casc_up = 1'b1;
   logic [7:0] lo_q, hi_q;
   logic       lo_co, hi_co, lo_err, hi_err;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   bcd_updown_counter dut (
      .clk(clk), .reset(reset), .en(en), .up(up), .ld(ld), .din(din),
      .q(q), .co(co), .err(err)
   );

   bcd_updown_counter lo (
      .clk(clk), .reset(reset), .en(casc_en), .up(casc_up), .ld(1'b0), .din(8'h00),
      .q(lo_q), .co(lo_co), .err(lo_err)
   );

   bcd_updown_counter hi (
      .clk(clk), .reset(reset), .en(lo_co), .up(casc_up), .ld(1'b0), .din(8'h00),
      .q(hi_q), .co(hi_co), .err(hi_err)
   );

   function automatic logic [7:0] enc(input int n);
      logic [3:0] t;
      logic [3:0] o;
      t = 4'(n / 10);
      o = 4'(n % 10);
      return {t, o};
   endfunction

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1; ld = 1'b1; din = 8'h57; en = 1'b0; up = 1'b1;
      @(negedge clk);
      reset = 1'b0; ld = 1'b0;
      #1;
      total++;
      if (q !== 8'h00) begin bad++; $display("FAIL reset_q: got %h want 00", q); end
      total++;
      if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
      total++;
      if (co !== 1'b0) begin bad++; $display("FAIL reset_co_idle: got %b want 0", co); end
      en = 1'b1; up = 1'b0;
      #1;
      total++;
      if (co !== 1'b1) begin bad++; $display("FAIL reset_co_down: got %b want 1", co); end
      up = 1'b1;
      #1;
      total++;
      if (co !== 1'b0) begin bad++; $display("FAIL reset_co_up: got %b want 0", co); end
      en = 1'b0;
   endtask

   task automatic test_count_up();
      logic [7:0] wrap_exp;
      @(negedge clk);
      reset = 1'b1; en = 1'b0; ld = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 100; i++) begin
         en = 1'b1; up = 1'b1;
         #1;
         total++;
         if (q !== enc(i)) begin bad++; $display("FAIL up_q[%0d]: got %h want %h", i, q, enc(i)); end
         total++;
         if (co !== (i == 99)) begin bad++; $display("FAIL up_co[%0d]: got %b want %b", i, co, (i == 99)); end
         @(negedge clk);
      end
      en = 1'b0;
`ifdef BCD_SATURATE_EN
      wrap_exp = 8'h99;
`else
      wrap_exp = 8'h00;
`endif
      #1;
      total++;
      if (q !== wrap_exp) begin bad++; $display("FAIL up_wrap: got %h want %h", q, wrap_exp); end
   endtask

   task automatic test_load_down();
      logic [7:0] wrap_exp;
      @(negedge clk);
      ld = 1'b1; din = 8'h10; en = 1'b0;
      @(negedge clk);
      ld = 1'b0; en = 1'b1; up = 1'b0;
      #1;
      total++;
      if (q !== 8'h10) begin bad++; $display("FAIL down_load: got %h want 10", q); end
      @(negedge clk);
      total++;
      if (q !== 8'h09) begin bad++; $display("FAIL down_09: got %h want 09", q); end
      @(negedge clk);
      en = 1'b0;
      total++;
      if (q !== 8'h08) begin bad++; $display("FAIL down_08: got %h want 08", q); end
      ld = 1'b1; din = 8'h00;
      @(negedge clk);
      ld = 1'b1; en = 1'b1; up = 1'b0; din = 8'h00;
      #1;
      total++;
      if (co !== 1'b0) begin bad++; $display("FAIL down_co_ld_mask: got %b want 0", co); end
      ld = 1'b0;
      #1;
      total++;
      if (co !== 1'b1) begin bad++; $display("FAIL down_co_zero: got %b want 1", co); end
      @(negedge clk);
      en = 1'b0;
`ifdef BCD_SATURATE_EN
      wrap_exp = 8'h00;
`else
      wrap_exp = 8'h99;
`endif
      total++;
      if (q !== wrap_exp) begin bad++; $display("FAIL down_wrap: got %h want %h", q, wrap_exp); end
   endtask

   task automatic test_invalid_load();
      @(negedge clk);
      ld = 1'b1; din = 8'h27; en = 1'b0;
      @(negedge clk);
      ld = 1'b1; din = 8'h3C; en = 1'b1; up = 1'b1;
      @(negedge clk);
      total++;
      if (q !== 8'h27) begin bad++; $display("FAIL bad_ld_q: got %h want 27", q); end
      total++;
      if (err !== 1'b1) begin bad++; $display("FAIL bad_ld_err: got %b want 1", err); end
      ld = 1'b1; din = 8'h42; en = 1'b0;
      @(negedge clk);
      total++;
      if (q !== 8'h42) begin bad++; $display("FAIL good_ld_q: got %h want 42", q); end
      total++;
      if (err !== 1'b0) begin bad++; $display("FAIL good_ld_err: got %b want 0", err); end
      ld = 1'b1; din = 8'hA5;
      @(negedge clk);
      ld = 1'b0; en = 1'b1; up = 1'b1;
      repeat (3) @(negedge clk);
      en = 1'b0;
      total++;
      if (q !== 8'h45) begin bad++; $display("FAIL sticky_q: got %h want 45", q); end
      total++;
      if (err !== 1'b1) begin bad++; $display("FAIL sticky_err: got %b want 1", err); end
      reset = 1'b1; ld = 1'b1; din = 8'h33;
      @(negedge clk);
      reset = 1'b0; ld = 1'b0;
      total++;
      if (err !== 1'b0 || q !== 8'h00) begin
         bad++; $display("FAIL reset_clears_err: got q=%h err=%b want q=00 err=0", q, err);
      end
   endtask

   task automatic test_direction_toggle();
      logic [7:0] exp_seq [4];
      exp_seq[0] = 8'h50; exp_seq[1] = 8'h49; exp_seq[2] = 8'h50; exp_seq[3] = 8'h49;
      @(negedge clk);
      ld = 1'b1; din = 8'h49; en = 1'b0;
      @(negedge clk);
      ld = 1'b0;
      for (int i = 0; i < 4; i++) begin
         en = 1'b1; up = (i % 2 == 0);
         @(negedge clk);
         total++;
         if (q !== exp_seq[i] || q[3:0] > 4'd9) begin
            bad++; $display("FAIL toggle[%0d]: got %h want %h", i, q, exp_seq[i]);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      ld = 1'b1; din = 8'h12; en = 1'b1; up = 1'b1;
      @(negedge clk);
      total++;
      if (q !== 8'h12) begin bad++; $display("FAIL b2b_ld_over_en: got %h want 12", q); end
      din = 8'h34;
      @(negedge clk);
      total++;
      if (q !== 8'h34) begin bad++; $display("FAIL b2b_second_ld: got %h want 34", q); end
      ld = 1'b0;
      @(negedge clk);
      total++;
      if (q !== 8'h35) begin bad++; $display("FAIL b2b_count_after: got %h want 35", q); end
      en = 1'b1; up = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; en = 1'b0;
      total++;
      if (q !== 8'h00) begin bad++; $display("FAIL b2b_reset_mid_count: got %h want 00", q); end
   endtask

   task automatic test_cascade();
      logic [15:0] exp_v;
      @(negedge clk);
      reset = 1'b1; casc_en = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 10000; i++) begin
         casc_en = 1'b1; casc_up = 1'b1;
         #1;
         exp_v = {enc(i / 100), enc(i % 100)};
         total++;
         if ({hi_q, lo_q} !== exp_v) begin
            bad++; $display("FAIL casc_q[%0d]: got %h%h want %h", i, hi_q, lo_q, exp_v);
         end
         total++;
         if (hi_co !== (i == 9999)) begin
            bad++; $display("FAIL casc_co[%0d]: got %b want %b", i, hi_co, (i == 9999));
         end
         @(negedge clk);
      end
      casc_en = 1'b0;
`ifdef BCD_SATURATE_EN
      exp_v = 16'h9999;
`else
      exp_v = 16'h0000;
`endif
      #1;
      total++;
      if ({hi_q, lo_q} !== exp_v) begin
         bad++; $display("FAIL casc_wrap: got %h%h want %h", hi_q, lo_q, exp_v);
      end
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_load_down();
      test_invalid_load();
      test_direction_toggle();
      test_back_to_back();
      test_cascade();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled only on rising clk.
REQ-004 en  input  1  count enable; one step per cycle while high.
REQ-005 up  input  1  direction: 1 = increment, 0 = decrement; sampled together with en.
REQ-006 ld  input  1  parallel load strobe.
REQ-007 din  input  8  load value: din[7:4] = tens digit, din[3:0] = ones digit, both BCD.
REQ-008 q  output  8  registered count: q[7:4] = tens, q[3:0] = ones (the ones digit feeds the downstream BCD-to-decimal decoder).
REQ-009 co  output  1  combinational terminal-count / carry-borrow for cascading.
REQ-010 err  output  1  registered sticky flag: a non-BCD load was rejected.

Function
REQ-011 q SHALL always hold two valid BCD digits (each 0-9); codes 1010-1111 never appear on either digit.
REQ-012 Priority per rising clk SHALL be: reset > ld > en; with none asserted, q holds.
REQ-013 Load, valid (both din nibbles <= 9): q <= din next cycle; err <= 0.
REQ-014 Load, invalid (either nibble > 9): q holds; err <= 1; no count happens that cycle even if en = 1.
REQ-015 Count up (en = 1, up = 1, ld = 0): ones 0-8 increments; ones 9 goes to 0 and tens increments; tens 9 with ones 9 is the terminal count.
REQ-016 Count down (en = 1, up = 0, ld = 0): ones 1-9 decrements; ones 0 goes to 9 and tens decrements; 00 is the terminal count.
REQ-017 Latency SHALL be one clk from a sampled en/ld to the updated q; there is no pipelining.
REQ-018 co SHALL be en & ~ld & ((up & q == 8'h99) | (~up & q == 8'h00)); it is purely combinational with no register stage.
REQ-019 A direction change while enabled SHALL take effect on the same edge it is sampled; no idle cycle is required.
REQ-020 err SHALL stay set until reset or a valid load; counting does not clear it.
REQ-021 Cascading: co of a lower instance drives en of the next instance, with up shared between them; the combined count SHALL be exact decimal.

Reset
REQ-022 On reset at a rising clk: q = 8'h00 and err = 0; co then follows REQ-018 (co = 1 only if en = 1 and up = 0).
REQ-023 Reset asserted mid-count or concurrently with ld SHALL win; din is ignored that cycle.
REQ-024 After reset, q SHALL be valid BCD without any further stimulus; there is no X propagation from din.

Configuration
REQ-025 Macro BCD_SATURATE_EN: when defined, count up at 99 holds at 99, and count down at 00 holds at 00.
REQ-026 Without BCD_SATURATE_EN, count up at 99 wraps to 00 and count down at 00 wraps to 99.
REQ-027 co timing and value per REQ-018 SHALL be identical in both configurations; only the next-state q differs.

Verification
REQ-028 reset = 1 for 1 clk with din = 8'h57 and ld = 1 -> q = 8'h00, err = 0.
REQ-029 Reset, then en = 1, up = 1 for 100 clks -> q steps 00,01,...,09,10,...,99. co = 1 only while q = 99. The next q is 00 (wrap) or 99 (BCD_SATURATE_EN).
REQ-030 ld = 1, din = 8'h10, then en = 1, up = 0 for 2 clks -> q = 10, 09, 08; at q = 00 with up = 0, co = 1.
REQ-031 ld = 1, din = 8'h3C, en = 1 -> q unchanged, err = 1; then ld = 1, din = 8'h42 -> q = 42, err = 0.
REQ-032 q = 8'h49, en = 1, toggle up each clk -> q = 50, 49, 50, 49; every ones nibble stays <= 9 and every q[3:0] value decodes one-hot downstream.
REQ-033 Two cascaded instances, lower co driving upper en, up = 1, 10000 clks from 0000 -> combined count wraps to 0000; upper co = 1 only at 9999.
